branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/btb_pkg.sv | 22 ++
 rtl/branch_target_buffer_if.sv | 49 ++++
 rtl/branch_target_buffer_sat_counter2.sv | 24 ++
 rtl/branch_target_buffer.sv | 124 ++++++++++++
 tb/tb_branch_target_buffer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer.
//   ctr_e       : 2-bit saturating direction counter encoding
//   BTB_ENTRIES : default number of direct-mapped entries
//   PC_INC      : fall-through increment used for the not-taken redirect PC
package btb_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int unsigned BTB_ENTRIES = 16;
  localparam logic [31:0] PC_INC      = 32'd4;

  // The counter MSB alone separates the taken states (WT, ST) from the rest.
  function automatic logic ctr_taken(input ctr_e c);
    return c[1];
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Bus between the fetch/decode pipeline and the branch target buffer.
//   master : pipeline side (drives the fetch PC and resolved-branch update)
//   slave  : BTB side (returns the prediction and the mispredict redirect)
// Optional: BTB_STATS_EN adds BranchCount / MispredictCount.
interface branch_target_buffer_if;

  logic [31:0] FetchPC;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        UpdateValid;
  logic [31:0] UpdatePC;
  logic [31:0] UpdateTarget;
  logic        BranchResult;
  logic        UpdPredTaken;
  logic [31:0] UpdPredTarget;
  logic        Mispredict;
  logic [31:0] CorrectPC;
`ifdef BTB_STATS_EN
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  modport master (
    output FetchPC, UpdateValid, UpdatePC, UpdateTarget, BranchResult,
           UpdPredTaken, UpdPredTarget,
    input  PredTaken, PredTarget, Mispredict, CorrectPC,
           BranchCount, MispredictCount
  );

  modport slave (
    input  FetchPC, UpdateValid, UpdatePC, UpdateTarget, BranchResult,
           UpdPredTaken, UpdPredTarget,
    output PredTaken, PredTarget, Mispredict, CorrectPC,
           BranchCount, MispredictCount
  );
`else
  modport master (
    output FetchPC, UpdateValid, UpdatePC, UpdateTarget, BranchResult,
           UpdPredTaken, UpdPredTarget,
    input  PredTaken, PredTarget, Mispredict, CorrectPC
  );

  modport slave (
    input  FetchPC, UpdateValid, UpdatePC, UpdateTarget, BranchResult,
           UpdPredTaken, UpdPredTarget,
    output PredTaken, PredTarget, Mispredict, CorrectPC
  );
`endif

endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state logic for the 2-bit saturating direction counter.
//   state : current counter value
//   taken : resolved branch direction
//   next  : counter value after training on this outcome
module sat_counter2
  import btb_pkg::*;
(
  input  ctr_e state,
  input  logic taken,
  output ctr_e next
);

  always_comb begin
    next = state;
    unique case (state)
      SNT: next = taken ? WNT : SNT;
      WNT: next = taken ? WT  : SNT;
      WT:  next = taken ? ST  : WNT;
      ST:  next = taken ? ST  : WT;
      default: next = state;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
//   Clk : rising-edge clock
//   Rst : asynchronous active-low reset
//   bus : branch_target_buffer_if.slave
//         lookup  : FetchPC -> PredTaken, PredTarget (combinational)
//         update  : UpdateValid/UpdatePC/UpdateTarget/BranchResult train the
//                   table on the rising edge; UpdPredTaken/UpdPredTarget are
//                   compared against the outcome to raise Mispredict and
//                   CorrectPC (combinational)
// Optional: BTB_STATS_EN adds saturating BranchCount / MispredictCount.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  branch_target_buffer_if.slave bus
);

  localparam int TAG_W = 30 - IDX_W;

  logic             valid   [ENTRIES];
  ctr_e             ctr     [ENTRIES];
  logic [TAG_W-1:0] tag_mem [ENTRIES];
  logic [31:0]      tgt_mem [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  ctr_e             ctr_next;
  logic             mispredict;

  // Byte offset of the PC never selects anything.
  logic unused_fetch_lsb;
  assign unused_fetch_lsb = ^bus.FetchPC[1:0];

  // Lookup reads the stored arrays directly, so an update on the same index
  // in the same cycle is seen only after the edge.
  assign fetch_idx = bus.FetchPC[IDX_W+1:2];
  assign fetch_tag = bus.FetchPC[31:IDX_W+2];
  assign fetch_hit = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

  assign bus.PredTaken  = fetch_hit && ctr_taken(ctr[fetch_idx]);
  assign bus.PredTarget = fetch_hit ? tgt_mem[fetch_idx] : 32'd0;

  assign upd_idx = bus.UpdatePC[IDX_W+1:2];
  assign upd_tag = bus.UpdatePC[31:IDX_W+2];
  assign upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  sat_counter2 u_sat_counter2 (
    .state (ctr[upd_idx]),
    .taken (bus.BranchResult),
    .next  (ctr_next)
  );

  // Qualified by Rst so an update presented while reset is held neither
  // flushes the pipeline nor counts as a mispredict.
  assign mispredict = Rst && bus.UpdateValid &&
                      ((bus.BranchResult != bus.UpdPredTaken) ||
                       (bus.BranchResult && bus.UpdPredTaken &&
                        (bus.UpdPredTarget != bus.UpdateTarget)));

  assign bus.Mispredict = mispredict;
  assign bus.CorrectPC  = bus.BranchResult ? bus.UpdateTarget
                                           : bus.UpdatePC + PC_INC;

  // Valid bits and counters carry reset state; a miss that resolves
  // not-taken leaves the table untouched.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr[i]   <= WNT;
      end
    end else if (bus.UpdateValid) begin
      if (upd_hit) begin
        ctr[upd_idx] <= ctr_next;
      end else if (bus.BranchResult) begin
        valid[upd_idx] <= 1'b1;
        ctr[upd_idx]   <= WT;
      end
    end
  end

  // Tags and targets need no reset: they are only observed through a valid
  // entry. Any taken outcome writes the target, whether hit or allocate.
  always_ff @(posedge Clk) begin
    if (Rst && bus.UpdateValid && bus.BranchResult) begin
      tgt_mem[upd_idx] <= bus.UpdateTarget;
      if (!upd_hit) begin
        tag_mem[upd_idx] <= upd_tag;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      if (bus.UpdateValid && (branch_cnt != 32'hFFFF_FFFF)) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

  assign bus.BranchCount     = branch_cnt;
  assign bus.MispredictCount = mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: a behavioural table model
// produces expected outputs, which are queued when stimulus is driven and
// compared when the outputs are sampled on the falling edge.
module tb_branch_target_buffer;
  import btb_pkg::*;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  branch_target_buffer_if bus ();

  branch_target_buffer #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] cpc;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t sb[$];

  logic        m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) & (ENTRIES - 1));
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bcnt = 32'd0;
    m_mcnt = 32'd0;
  endtask

  // One clock of stimulus. Called #1 after a rising edge; returns #1 after
  // the next rising edge with the model trained on the same edge as the DUT.
  task automatic cycle(input string name, input logic [31:0] fpc,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic br, input logic upt, input logic [31:0] uptgt);
    exp_t e;
    exp_t g;
    int   i;
    logic hit;

    bus.FetchPC       = fpc;
    bus.UpdateValid   = uv;
    bus.UpdatePC      = upc;
    bus.UpdateTarget  = utgt;
    bus.BranchResult  = br;
    bus.UpdPredTaken  = upt;
    bus.UpdPredTarget = uptgt;

    i      = m_idx(fpc);
    hit    = m_valid[i] && (m_tag[i] == m_tagof(fpc));
    e.name = name;
    e.pt   = hit && (m_ctr[i] >= 2);
    e.ptgt = hit ? m_tgt[i] : 32'd0;
    e.mp   = Rst && uv && ((br != upt) || (br && upt && (uptgt != utgt)));
    e.cpc  = br ? utgt : upc + 32'd4;
    e.bcnt = m_bcnt;
    e.mcnt = m_mcnt;
    sb.push_back(e);

    @(negedge Clk);
    g = sb.pop_front();
    check_val({g.name, ".pred_taken"},  {31'd0, bus.PredTaken},  {31'd0, g.pt});
    check_val({g.name, ".pred_target"}, bus.PredTarget,          g.ptgt);
    check_val({g.name, ".mispredict"},  {31'd0, bus.Mispredict}, {31'd0, g.mp});
    check_val({g.name, ".correct_pc"},  bus.CorrectPC,           g.cpc);
`ifdef BTB_STATS_EN
    check_val({g.name, ".branch_cnt"},  bus.BranchCount,         g.bcnt);
    check_val({g.name, ".mispred_cnt"}, bus.MispredictCount,     g.mcnt);
`endif

    @(posedge Clk);
    if (Rst && uv) begin
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
      if (e.mp && (m_mcnt != 32'hFFFF_FFFF)) m_mcnt = m_mcnt + 32'd1;
      i   = m_idx(upc);
      hit = m_valid[i] && (m_tag[i] == m_tagof(upc));
      if (hit) begin
        if (br) begin
          if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
          m_tgt[i] = utgt;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i] = m_ctr[i] - 1;
        end
      end else if (br) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(upc);
        m_tgt[i]   = utgt;
        m_ctr[i]   = 2;
      end
    end
    #1;
  endtask

  task automatic lookup(input string name, input logic [31:0] fpc);
    cycle(name, fpc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  logic [31:0] pcs [5];

  initial begin
    pcs[0] = 32'h0040_0010;
    pcs[1] = 32'h0040_0050;
    pcs[2] = 32'h0040_0090;
    pcs[3] = 32'h0040_0014;
    pcs[4] = 32'h0080_0020;

    model_reset();
    bus.FetchPC = 32'd0; bus.UpdateValid = 1'b0; bus.UpdatePC = 32'd0;
    bus.UpdateTarget = 32'd0; bus.BranchResult = 1'b0; bus.UpdPredTaken = 1'b0;
    bus.UpdPredTarget = 32'd0;

    // Held in reset: update must be dropped, Mispredict stays low.
    cycle("rst_upd", 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0, 32'd0);
    lookup("rst_look", 32'h0040_0010);
    Rst = 1'b1;

    lookup("post_rst", 32'h0040_0010);

    // Allocate on a taken miss, then hit.
    cycle("alloc", 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0, 32'd0);
    lookup("alloc_hit", 32'h0040_0010);

    // Not-taken training WT->WNT->SNT, with same-cycle lookup of the index.
    cycle("nt1", 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b0, 1'b1, 32'h0040_0100);
    cycle("nt2", 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b0, 1'b0, 32'd0);
    lookup("nt_done", 32'h0040_0010);

    // Not-taken miss leaves the table alone.
    cycle("nt_miss", 32'h0040_0090, 1'b1, 32'h0040_0090, 32'h0040_0500, 1'b0, 1'b0, 32'd0);
    lookup("nt_miss_look", 32'h0040_0090);

    // Alias on the same index replaces the occupant.
    cycle("alias", 32'h0040_0050, 1'b1, 32'h0040_0050, 32'h0040_0180, 1'b1, 1'b0, 32'd0);
    lookup("alias_old", 32'h0040_0010);
    lookup("alias_new", 32'h0040_0050);
    lookup("lsb_ignored", 32'h0040_0053);

    // Right direction, wrong target; then fall-through wrap at top of memory.
    cycle("bad_tgt", 32'h0040_0050, 1'b1, 32'h0040_0050, 32'h0040_0300, 1'b1, 1'b1, 32'h0040_0200);
    lookup("new_tgt", 32'h0040_0050);
    cycle("wrap", 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h0000_1234, 1'b0, 1'b0, 32'd0);

    // Saturation at ST, one not-taken keeps it predicting taken.
    for (int k = 0; k < 3; k++)
      cycle("sat_st", 32'h0040_0050, 1'b1, 32'h0040_0050, 32'h0040_0300, 1'b1, 1'b1, 32'h0040_0300);
    cycle("st_to_wt", 32'h0040_0050, 1'b1, 32'h0040_0050, 32'h0040_0300, 1'b0, 1'b1, 32'h0040_0300);
    lookup("wt_look", 32'h0040_0050);

    // Mixed random traffic on a small set of PCs.
    for (int k = 0; k < 60; k++) begin
      cycle("rand", pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
            pcs[$urandom_range(0, 4)], {$urandom_range(0, 255), 2'b00} + 32'h0040_1000,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom_range(0, 255), 2'b00} + 32'h0040_1000);
    end

    // Five allocations, then reset mid-stream.
    for (int k = 0; k < 5; k++)
      cycle("alloc5", 32'd0, 1'b1, 32'h0040_1000 + 32'(k * 4), 32'h0040_2000 + 32'(k * 16),
            1'b1, 1'b0, 32'd0);
    lookup("alloc5_hit", 32'h0040_1008);
    Rst = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++)
      lookup("rst_miss", 32'h0040_1000 + 32'(k * 4));
    Rst = 1'b1;
    lookup("rst_rel", 32'h0040_1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
